// File: rtl/clk_divider_prog.sv
// clk_divider_prog
// Runtime-programmable clock divider and tick generator. A single down-stream
// enable domain is derived from clk: clk_out is a registered square wave
// (mode=0) or a one-cycle pulse (mode=1), and tick strobes once per period.
// A new divisor is staged by div_load and swapped in only at a period
// boundary, so a divisor change never produces a runt period.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset_sync   synchronous active-high reset, highest priority
//   enable       count enable; low holds count, clk_out and divisor
//   mode         0 = square output, 1 = pulse output
//   div_in       requested divisor, sampled while div_load is high
//   div_load     single-cycle request to stage div_in
//   clk_out      registered divided waveform
//   tick         registered one-cycle strobe at the start of each period
//   div_active   divisor currently in use
//   div_pending  a staged divisor waits for the next period boundary
//   div_err      one-cycle pulse when a load with div_in < 2 is rejected
module clk_divider_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pending,
  output logic             div_err
);

  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default_div
    $error("clk_divider_prog: DEFAULT_DIV out of range 2 .. 2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] div_staged_q, div_staged_d;
  logic             div_pending_q, div_pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             div_err_q, div_err_d;

  logic             wrap;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] high_len;

  assign wrap      = enable && (count_q == div_active_q - ONE);
  assign count_inc = count_q + ONE;
  // ceil(D/2) of the divisor still in force on an advance edge
  assign high_len  = div_active_q - (div_active_q >> 1);

  always_comb begin
    count_d       = count_q;
    div_active_d  = div_active_q;
    div_staged_d  = div_staged_q;
    div_pending_d = div_pending_q;
    clk_out_d     = clk_out_q;
    tick_d        = 1'b0;
    div_err_d     = 1'b0;

    if (wrap) begin
      count_d   = '0;
      tick_d    = 1'b1;
      clk_out_d = 1'b1;
      if (div_pending_q) begin
        div_active_d  = div_staged_q;
        div_pending_d = 1'b0;
      end
    end else if (enable) begin
      count_d   = count_inc;
      clk_out_d = mode ? 1'b0 : (count_inc < high_len);
    end

    // Evaluated after the wrap so a load on the wrap edge stays pending for
    // the following period instead of being consumed immediately.
    if (div_load) begin
      if (div_in >= TWO) begin
        div_staged_d  = div_in;
        div_pending_d = 1'b1;
      end else begin
        div_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      count_q       <= DEF_DIV - ONE;
      div_active_q  <= DEF_DIV;
      div_staged_q  <= '0;
      div_pending_q <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      div_err_q     <= 1'b0;
    end else begin
      count_q       <= count_d;
      div_active_q  <= div_active_d;
      div_staged_q  <= div_staged_d;
      div_pending_q <= div_pending_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      div_err_q     <= div_err_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign div_active  = div_active_q;
  assign div_pending = div_pending_q;
  assign div_err     = div_err_q;

endmodule
